// File: rtl/jtframe_pll_phase_ctrl.sv
// Run-time phase-shift sequencer for the SDRAM clock of the system PLL.
// Steps the altpll dynamic-phase port until a signed target position is reached.
module jtframe_pll_phase_ctrl #(
    parameter logic [3:0] CNTSEL    = 4'b0011,
    parameter int         POSW      = 8,
    parameter int         STEP_HOLD = 2,
    parameter int         TIMEOUT   = 255,
    parameter int         SETTLE    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pll_locked,
    input  logic                   pll_phasedone,
    input  logic                   go,
    input  logic signed [POSW-1:0] target,
    output logic                   phasestep,
    output logic                   phaseupdown,
    output logic [3:0]             phasecounterselect,
    output logic signed [POSW-1:0] pos,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    localparam int CMAX_A = (TIMEOUT > SETTLE) ? TIMEOUT : SETTLE;
    localparam int CMAX   = (CMAX_A > STEP_HOLD) ? CMAX_A : STEP_HOLD;
    localparam int CW     = $clog2(CMAX + 1);

    localparam logic [CW-1:0] HOLD_END = CW'(STEP_HOLD - 1);
    localparam logic [CW-1:0] TO_END   = CW'(TIMEOUT);
    localparam logic [CW-1:0] SET_END  = CW'(SETTLE - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic signed [POSW-1:0] POS_ONE = POSW'(1);

    typedef enum logic [2:0] {
        S_WAIT_LOCK,
        S_IDLE,
        S_STEP,
        S_WAIT_LOW,
        S_WAIT_HIGH,
        S_SETTLE
    } state_t;

    state_t                 state;
    logic [CW-1:0]          cnt;
    logic signed [POSW-1:0] tgt;
    logic signed [POSW-1:0] pos_nxt;
    logic                   lk_meta, lk;
    logic                   pd_meta, pd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lk_meta <= 1'b0;
            lk      <= 1'b0;
            pd_meta <= 1'b0;
            pd      <= 1'b0;
        end else begin
            lk_meta <= pll_locked;
            lk      <= lk_meta;
            pd_meta <= pll_phasedone;
            pd      <= pd_meta;
        end
    end

    always_comb begin
        pos_nxt = phaseupdown ? pos + POS_ONE : pos - POS_ONE;
    end

    assign phasecounterselect = busy ? CNTSEL : 4'b0000;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_WAIT_LOCK;
            cnt         <= '0;
            tgt         <= '0;
            pos         <= '0;
            phasestep   <= 1'b0;
            phaseupdown <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state != S_WAIT_LOCK && !lk) begin
                // the PLL relocks at its compiled phase, so the offset is lost
                state     <= S_WAIT_LOCK;
                phasestep <= 1'b0;
                pos       <= '0;
                err       <= 1'b1;
                busy      <= 1'b1;
                cnt       <= '0;
            end else begin
                unique case (state)
                    S_WAIT_LOCK: begin
                        if (lk) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    S_IDLE: begin
                        if (go) begin
                            tgt  <= target;
                            err  <= 1'b0;
                            busy <= 1'b1;
                            cnt  <= '0;
                            if (target == pos) begin
                                state <= S_SETTLE;
                            end else begin
                                state       <= S_STEP;
                                phasestep   <= 1'b1;
                                phaseupdown <= (target > pos);
                            end
                        end
                    end
                    S_STEP: begin
                        if (cnt == HOLD_END) begin
                            phasestep <= 1'b0;
                            cnt       <= '0;
                            state     <= S_WAIT_LOW;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    S_WAIT_LOW: begin
                        if (!pd) begin
                            cnt   <= '0;
                            state <= S_WAIT_HIGH;
                        end else if (cnt == TO_END) begin
                            err   <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    S_WAIT_HIGH: begin
                        if (pd) begin
                            pos <= pos_nxt;
                            cnt <= '0;
                            if (pos_nxt == tgt) begin
                                state <= S_SETTLE;
                            end else begin
                                state     <= S_STEP;
                                phasestep <= 1'b1;
                            end
                        end else if (cnt == TO_END) begin
                            err   <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    S_SETTLE: begin
                        if (cnt == SET_END) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    default: state <= S_WAIT_LOCK;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_jtframe_pll_phase_ctrl.sv
// Bench for jtframe_pll_phase_ctrl: PLL phasedone model plus
// scenario tasks checked against a queue of expected outcomes.
module tb_jtframe_pll_phase_ctrl;

    localparam int STEP_HOLD = 2;
    localparam int TIMEOUT   = 255;
    localparam int SETTLE    = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              pll_locked = 1'b1;
    logic              pll_phasedone = 1'b1;
    logic              go = 1'b0;
    logic signed [7:0] target = '0;
    logic              phasestep, phaseupdown, busy, done, err;
    logic [3:0]        phasecounterselect;
    logic signed [7:0] pos;

    jtframe_pll_phase_ctrl dut (
        .clk                (clk),
        .rst                (rst),
        .pll_locked         (pll_locked),
        .pll_phasedone      (pll_phasedone),
        .go                 (go),
        .target             (target),
        .phasestep          (phasestep),
        .phaseupdown        (phaseupdown),
        .phasecounterselect (phasecounterselect),
        .pos                (pos),
        .busy               (busy),
        .done               (done),
        .err                (err)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    bit pd_stuck = 1'b0;

    typedef struct {
        int                steps;
        logic signed [7:0] pos;
        logic              up;
        logic              err;
    } exp_t;
    exp_t sb[$];

    // PLL model and bus monitor
    int   rises = 0, ups = 0, dns = 0, wbad = 0, sbad = 0, dones = 0;
    int   run = 0, pd_t = 0;
    logic ps_q = 1'b0;

    always @(negedge clk) begin
        if (pd_t != 0) begin
            pd_t++;
            if (pd_t == 4) pll_phasedone = 1'b0;
            else if (pd_t == 9) begin
                pll_phasedone = 1'b1;
                pd_t = 0;
            end
        end
        if (phasestep && !ps_q) begin
            rises++;
            if (phaseupdown) ups++;
            else dns++;
            if (!pd_stuck) pd_t = 1;
        end
        if (phasestep) begin
            run++;
            if (phasecounterselect !== 4'b0011) sbad++;
        end else if (run != 0) begin
            if (run != STEP_HOLD) wbad++;
            run = 0;
        end
        if (done) dones++;
        ps_q = phasestep;
    end

    task automatic pulse_go(input logic signed [7:0] t);
        @(negedge clk);
        go = 1'b1;
        target = t;
        @(negedge clk);
        go = 1'b0;
        target = ~t;
    endtask

    task automatic wait_end(output int cyc, output bit hit);
        cyc = 1;
        hit = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (done || err) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        pll_locked = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({phasestep, phaseupdown, phasecounterselect, pos, busy, done, err} !== 17'd0)
            $display("FAIL reset_outputs: got %h want 0",
                {phasestep, phaseupdown, phasecounterselect, pos, busy, done, err});
        else passed++;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({busy, err, done} !== 3'b000)
            $display("FAIL reset_idle: busy/err/done=%b want 000", {busy, err, done});
        else passed++;
    endtask

    task automatic test_move(input logic signed [7:0] t, input int steps, input logic up);
        int r0, u0, d0, w0, s0, k0, cyc;
        bit hit;
        exp_t e;
        r0 = rises; u0 = ups; d0 = dns; w0 = wbad; s0 = sbad; k0 = dones;
        sb.push_back('{steps: steps, pos: t, up: up, err: 1'b0});
        pulse_go(t);
        wait_end(cyc, hit);
        repeat (4) @(negedge clk);
        e = sb.pop_front();
        total++;
        if (!hit) $display("FAIL move_timeout: no done/err after %0d cycles", cyc);
        else passed++;
        total++;
        if (err !== e.err) $display("FAIL move_err: got %b want %b", err, e.err);
        else passed++;
        total++;
        if (pos !== e.pos) $display("FAIL move_pos: got %0d want %0d", pos, e.pos);
        else passed++;
        total++;
        if (rises - r0 !== e.steps)
            $display("FAIL move_steps: got %0d want %0d", rises - r0, e.steps);
        else passed++;
        total++;
        if ((e.up ? ups - u0 : dns - d0) !== e.steps)
            $display("FAIL move_dir: up=%0d dn=%0d want %0d in dir %b",
                ups - u0, dns - d0, e.steps, e.up);
        else passed++;
        total++;
        if (wbad - w0 !== 0 || sbad - s0 !== 0)
            $display("FAIL move_pulse: width errs %0d sel errs %0d want 0", wbad - w0, sbad - s0);
        else passed++;
        total++;
        if (dones - k0 !== 1 || busy !== 1'b0)
            $display("FAIL move_done: dones %0d busy %b want 1/0", dones - k0, busy);
        else passed++;
    endtask

    task automatic test_equal(input logic signed [7:0] t, input bit check_err_clear);
        int r0, cyc;
        bit hit;
        exp_t e;
        r0 = rises;
        sb.push_back('{steps: 0, pos: t, up: 1'b0, err: 1'b0});
        pulse_go(t);
        total++;
        if (busy !== 1'b1 || (check_err_clear && err !== 1'b0))
            $display("FAIL equal_accept: busy %b err %b want 1/0", busy, err);
        else passed++;
        wait_end(cyc, hit);
        e = sb.pop_front();
        total++;
        if (!hit || !done || cyc !== SETTLE + 1)
            $display("FAIL equal_latency: done %b at %0d want 1 at %0d", done, cyc, SETTLE + 1);
        else passed++;
        total++;
        if (rises - r0 !== e.steps || err !== e.err || pos !== e.pos)
            $display("FAIL equal_state: steps %0d err %b pos %0d want %0d/%b/%0d",
                rises - r0, err, pos, e.steps, e.err, e.pos);
        else passed++;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_timeout();
        int r0, k0, cyc;
        bit hit;
        exp_t e;
        r0 = rises; k0 = dones;
        sb.push_back('{steps: 1, pos: pos, up: 1'b1, err: 1'b1});
        pd_stuck = 1'b1;
        pulse_go(8'sd5);
        wait_end(cyc, hit);
        e = sb.pop_front();
        total++;
        if (!hit || err !== e.err || cyc !== TIMEOUT + STEP_HOLD + 2)
            $display("FAIL timeout_err: err %b at %0d want 1 at %0d",
                err, cyc, TIMEOUT + STEP_HOLD + 2);
        else passed++;
        total++;
        if (busy !== 1'b0 || pos !== e.pos || rises - r0 !== e.steps || dones - k0 !== 0)
            $display("FAIL timeout_state: busy %b pos %0d steps %0d dones %0d want 0/%0d/%0d/0",
                busy, pos, rises - r0, dones - k0, e.pos, e.steps);
        else passed++;
        pd_stuck = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_lock_loss();
        int   seen, k0, r1, lowat;
        logic prev;
        seen = 0; prev = 1'b0; k0 = dones;
        pulse_go(8'sd4);
        for (int i = 0; i < 200 && seen < 2; i++) begin
            if (phasestep && !prev) seen++;
            prev = phasestep;
            if (seen < 2) @(negedge clk);
        end
        total++;
        if (seen !== 2) $display("FAIL lock_step2: saw %0d steps want 2", seen);
        else passed++;
        pll_locked = 1'b0;
        lowat = -1;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            if (!phasestep && lowat < 0) lowat = i;
        end
        total++;
        if (lowat < 0) $display("FAIL lock_phasestep: still high 3 cycles after pin, want 0");
        else passed++;
        r1 = rises;
        repeat (20) @(negedge clk);
        total++;
        if (pos !== 8'sd0 || err !== 1'b1 || busy !== 1'b1)
            $display("FAIL lock_state: pos %0d err %b busy %b want 0/1/1", pos, err, busy);
        else passed++;
        total++;
        if (rises !== r1 || dones - k0 !== 0)
            $display("FAIL lock_quiet: new steps %0d dones %0d want 0/0", rises - r1, dones - k0);
        else passed++;
        pll_locked = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (busy !== 1'b0) $display("FAIL lock_relock: busy %b want 0", busy);
        else passed++;
    endtask

    initial begin
        #900us;
        $display("FAIL watchdog: simulation did not finish, got hang want finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_move(8'sd3, 3, 1'b1);
        test_move(-8'sd2, 5, 1'b0);
        total++;
        if (pos !== 8'hFE) $display("FAIL pos_hex: got %h want fe", pos);
        else passed++;
        test_equal(-8'sd2, 1'b0);
        test_timeout();
        test_equal(-8'sd2, 1'b1);
        test_lock_loss();
        test_move(8'sd1, 1, 1'b1);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
